// File: rtl/song_sequencer_pkg.sv
// Shared types and widths for the song sequencer, song ROM and tone generator.
package song_sequencer_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned NOTE_W = 4;
  localparam int unsigned DUR_W  = 32;
  localparam int unsigned SONG_W = 4;

  localparam logic [NOTE_W-1:0] NOTE_REST    = '0;
  localparam logic [DUR_W-1:0]  END_DURATION = '0;
  localparam logic [ADDR_W-1:0] ADDR_LAST    = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_GAP
  } state_e;

  // One song ROM entry as seen at the sequencer.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
  } rom_entry_t;

endpackage

// File: rtl/song_sequencer_if.sv
// Control, ROM and tone-generator signals of the song sequencer.
interface song_sequencer_if;
  import song_sequencer_pkg::*;

  logic              start;
  logic              pause;
  logic              stop;
  logic              loop_en;
  logic [SONG_W-1:0] song_sel;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_duration;
  logic [ADDR_W-1:0] rom_addr;
  logic [SONG_W-1:0] rom_song;
  logic [NOTE_W-1:0] note_out;
  logic              busy;
  logic              done;

  modport master (
    output start, pause, stop, loop_en, song_sel, rom_note, rom_duration,
    input  rom_addr, rom_song, note_out, busy, done
  );

  modport slave (
    input  start, pause, stop, loop_en, song_sel, rom_note, rom_duration,
    output rom_addr, rom_song, note_out, busy, done
  );
endinterface

// File: rtl/song_sequencer_note_timer.sv
// Loadable down-counter timing both note and articulation-gap phases.
module note_timer
  import song_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             en,
  output logic             tc_c
);

  logic [DUR_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - DUR_W'(1);
    end
  end

  // Last counted cycle of the phase.
  assign tc_c = (count_q == DUR_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// Walks the song ROM and emits a timed note stream with articulation gaps.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 100_000
)
(
  input  logic             clk,
  input  logic             rst_n,
  song_sequencer_if.slave  bus
);

  localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_CYCLES);
  localparam bit               HAS_GAP  = (GAP_CYCLES != 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [SONG_W-1:0] rom_song_q, rom_song_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [NOTE_W-1:0] note_out_q, note_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pause_q;
  logic              adv_c;
  logic              tmr_load_c, tmr_en_c, tmr_tc_c;
  logic [DUR_W-1:0]  tmr_val_c;
  rom_entry_t        entry_c;

  assign entry_c = '{note: bus.rom_note, duration: bus.rom_duration};

  note_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .en       (tmr_en_c),
    .tc_c     (tmr_tc_c)
  );

  // Pause is registered so muting and counting refer to the same cycles.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rom_song_d = rom_song_q;
    note_d     = note_q;
    done_d     = 1'b0;
    adv_c      = 1'b0;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    tmr_en_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          rom_song_d = bus.song_sel;
          rom_addr_d = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (entry_c.duration == END_DURATION) begin
          if (bus.loop_en && (rom_addr_q != '0)) begin
            rom_addr_d = '0;
          end else begin
            done_d     = 1'b1;
            rom_addr_d = '0;
            state_d    = ST_IDLE;
          end
        end else begin
          note_d     = entry_c.note;
          tmr_load_c = 1'b1;
          tmr_val_c  = entry_c.duration;
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (!pause_q) begin
          tmr_en_c = 1'b1;
          if (tmr_tc_c) begin
            if (HAS_GAP) begin
              tmr_load_c = 1'b1;
              tmr_val_c  = GAP_LOAD;
              state_d    = ST_GAP;
            end else begin
              adv_c = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        if (!pause_q) begin
          tmr_en_c = 1'b1;
          adv_c    = tmr_tc_c;
        end
      end
    endcase

    // Running off the top of the address space counts as an end marker.
    if (adv_c) begin
      if (rom_addr_q == ADDR_LAST) begin
        rom_addr_d = '0;
        if (bus.loop_en) begin
          state_d = ST_FETCH;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end else begin
        rom_addr_d = rom_addr_q + ADDR_W'(1);
        state_d    = ST_FETCH;
      end
    end

    if (bus.stop) begin
      state_d    = ST_IDLE;
      rom_addr_d = '0;
      rom_song_d = rom_song_q;
      done_d     = 1'b0;
      tmr_load_c = 1'b1;
      tmr_val_c  = '0;
      tmr_en_c   = 1'b0;
    end

    busy_d     = (state_d != ST_IDLE);
    note_out_d = ((state_d == ST_PLAY) && !bus.pause) ? note_d : NOTE_REST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      rom_song_q <= '0;
      note_q     <= '0;
      note_out_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pause_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      rom_song_q <= rom_song_d;
      note_q     <= note_d;
      note_out_q <= note_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pause_q    <= bus.pause && !bus.stop;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_song = rom_song_q;
  assign bus.note_out = note_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with stub ROMs, gap of 1 and gap of 0.
module tb_song_sequencer;
  import song_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  song_sequencer_if if1 ();
  song_sequencer_if if0 ();

  song_sequencer #(.GAP_CYCLES(1)) u_gap1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  song_sequencer #(.GAP_CYCLES(0)) u_gap0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  function automatic rom_entry_t rom_gap1(input logic [SONG_W-1:0] s, input logic [ADDR_W-1:0] a);
    rom_entry_t e;
    e = '0;
    if (s == SONG_W'(0)) begin
      if (a == ADDR_W'(0)) e = '{note: 4'd1, duration: 32'd3};
      if (a == ADDR_W'(1)) e = '{note: 4'd5, duration: 32'd2};
    end else if (s == SONG_W'(1)) begin
      if (a == ADDR_W'(0)) e = '{note: 4'd2, duration: 32'd10};
    end
    return e;
  endfunction

  function automatic rom_entry_t rom_gap0(input logic [SONG_W-1:0] s, input logic [ADDR_W-1:0] a);
    rom_entry_t e;
    e = '0;
    if (s == SONG_W'(0)) begin
      if (a == ADDR_W'(0)) e = '{note: 4'd3, duration: 32'd2};
      if (a == ADDR_W'(1)) e = '{note: 4'd0, duration: 32'd4};
      if (a == ADDR_W'(2)) e = '{note: 4'd4, duration: 32'd2};
    end
    return e;
  endfunction

  always_comb begin
    {if1.rom_note, if1.rom_duration} = rom_gap1(if1.rom_song, if1.rom_addr);
    {if0.rom_note, if0.rom_duration} = rom_gap0(if0.rom_song, if0.rom_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int trace1 [10] = '{0, 1, 1, 1, 0, 0, 5, 5, 0, 0};
  int trace0 [12] = '{0, 3, 3, 0, 0, 0, 0, 0, 0, 4, 4, 0};

  initial begin
    int hi, zeros_mid, pcnt, done_cnt;
    bit done_seen;
    {if1.start, if1.pause, if1.stop, if1.loop_en} = 4'b0;
    {if0.start, if0.pause, if0.stop, if0.loop_en} = 4'b0;
    if1.song_sel = '0;
    if0.song_sel = '0;

    // Reset state
    #12;
    check("rst_note", 32'(if1.note_out), 0);
    check("rst_busy", 32'(if1.busy), 0);
    check("rst_done", 32'(if1.done), 0);
    check("rst_addr", 32'(if1.rom_addr), 0);
    check("rst_song", 32'(if1.rom_song), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Song 0, gap 1, no loop
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    check("t1_busy", 32'(if1.busy), 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      check($sformatf("t1_note[%0d]", i), 32'(if1.note_out), 32'(trace1[i]));
      if (i == 9) check("t1_addr_end", 32'(if1.rom_addr), 2);
    end
    step();
    check("t1_done", 32'(if1.done), 1);
    check("t1_busy_fall", 32'(if1.busy), 0);
    check("t1_addr0", 32'(if1.rom_addr), 0);
    step();
    check("t1_done_once", 32'(if1.done), 0);

    // Loop mode, then stop
    if1.loop_en = 1'b1;
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    done_seen = 1'b0;
    for (int i = 1; i < 12; i++) begin
      step();
      done_seen |= if1.done;
      if (i == 9) check("t2_addr2", 32'(if1.rom_addr), 2);
      if (i == 10) check("t2_addr_wrap", 32'(if1.rom_addr), 0);
      if (i == 11) check("t2_replay", 32'(if1.note_out), 1);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      done_seen |= if1.done;
    end
    check("t2_no_done", 32'(done_seen), 0);
    check("t2_busy", 32'(if1.busy), 1);
    if1.stop = 1'b1;
    step();
    if1.stop = 1'b0;
    if1.loop_en = 1'b0;
    check("t2_stop_busy", 32'(if1.busy), 0);
    check("t2_stop_note", 32'(if1.note_out), 0);
    check("t2_stop_addr", 32'(if1.rom_addr), 0);
    check("t2_stop_done", 32'(if1.done), 0);

    // Pause in the middle of a 10-cycle note
    if1.song_sel = 4'd1;
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    check("t3_song", 32'(if1.rom_song), 1);
    hi = 0; zeros_mid = 0; pcnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (if1.done) done_cnt++;
      if (if1.note_out == 4'd2) hi++;
      else if (hi > 0 && hi < 10) zeros_mid++;
      if (if1.pause) begin
        pcnt++;
        if (pcnt == 4) if1.pause = 1'b0;
      end else if (hi == 3 && pcnt == 0) begin
        if1.pause = 1'b1;
      end
    end
    check("t3_high_cycles", 32'(hi), 10);
    check("t3_pause_zeros", 32'(zeros_mid), 4);
    check("t3_done_count", 32'(done_cnt), 1);

    // Gap 0 with a timed rest in the middle
    if0.start = 1'b1;
    step();
    if0.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      check($sformatf("t4_note[%0d]", i), 32'(if0.note_out), 32'(trace0[i]));
    end
    step();
    check("t4_done", 32'(if0.done), 1);
    check("t4_busy", 32'(if0.busy), 0);

    // Empty song with loop enabled must not spin
    if1.song_sel = 4'd2;
    if1.loop_en = 1'b1;
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    check("t5_fetch_busy", 32'(if1.busy), 1);
    step();
    check("t5_done", 32'(if1.done), 1);
    check("t5_idle", 32'(if1.busy), 0);
    step();
    check("t5_no_spin", 32'(if1.busy), 0);
    check("t5_done_clear", 32'(if1.done), 0);
    if1.loop_en = 1'b0;

    // Asynchronous reset mid-PLAY
    if1.song_sel = 4'd1;
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    step();
    step();
    check("t6_playing", 32'(if1.note_out), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_note", 32'(if1.note_out), 0);
    check("t6_rst_busy", 32'(if1.busy), 0);
    check("t6_rst_song", 32'(if1.rom_song), 0);
    step();
    rst_n = 1'b1;
    if1.song_sel = 4'd1;
    if1.start = 1'b1;
    step();
    if1.start = 1'b0;
    check("t6_song", 32'(if1.rom_song), 1);
    check("t6_addr", 32'(if1.rom_addr), 0);
    check("t6_busy", 32'(if1.busy), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
